// File: rtl/multi_center_of_mass.sv
// multi_center_of_mass
//   Per-channel centroid tracker for N_CH threshold masks sharing one pixel
//   stream. Each channel accumulates x/y sums and a pixel count during the
//   frame. On the frame-end strobe the totals are frozen into shadow registers.
//   One shared pair of restoring dividers (x and y in parallel) then walks the
//   channels in order and writes the centroid of every channel that saw enough
//   pixels.
//
//   Optional feature macro: COM_SMOOTH_EN. When it is defined, each stored
//   centroid is blended as (3*prev + new) >> 2 whenever the channel was already
//   found in the previous frame.
//
// Ports
//   clk_in         in   1          system clock
//   rst_in         in   1          synchronous active-high reset
//   x_in           in   X_W        pixel column, aligned with valid_in
//   y_in           in   Y_W        pixel row, aligned with valid_in
//   valid_in       in   N_CH       per-channel mask bit for this pixel
//   tabulate_in    in   1          frame-end strobe (single cycle)
//   x_com_out      out  N_CH*X_W   packed x centroids, channel c at [c*X_W +: X_W]
//   y_com_out      out  N_CH*Y_W   packed y centroids, channel c at [c*Y_W +: Y_W]
//   found_out      out  N_CH       channel reached MIN_PIXELS in last tabulated frame
//   valid_com_out  out  1          one-cycle pulse: all outputs updated
//   busy_out       out  1          divider sequence in progress
//   overrun_out    out  1          one-cycle pulse: tabulate_in arrived while busy
module multi_center_of_mass #(
  parameter int N_CH       = 2,
  parameter int X_W        = 11,
  parameter int Y_W        = 10,
  parameter int CNT_W      = 17,
  parameter int MIN_PIXELS = 16
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [N_CH-1:0]     valid_in,
  input  logic                tabulate_in,
  output logic [N_CH*X_W-1:0] x_com_out,
  output logic [N_CH*Y_W-1:0] y_com_out,
  output logic [N_CH-1:0]     found_out,
  output logic                valid_com_out,
  output logic                busy_out,
  output logic                overrun_out
);

  localparam int SX_W  = X_W + CNT_W;
  localparam int SY_W  = Y_W + CNT_W;
  localparam int SUM_W = SX_W;
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BC_W  = $clog2(SUM_W + 1);

  localparam logic [CNT_W-1:0] MIN_CNT  = CNT_W'(MIN_PIXELS);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(SUM_W - 1);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV,
    S_STORE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic              w_busy;
  logic              r_overrun;

  // Shared divider datapath
  logic [CH_W-1:0]   r_ch;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [SUM_W-1:0]  r_qx;
  logic [SUM_W-1:0]  r_qy;
  logic [CNT_W-1:0]  r_rx;
  logic [CNT_W-1:0]  r_ry;
  logic [CNT_W-1:0]  r_divisor;

  logic [CNT_W:0]    w_x_shift;
  logic [CNT_W:0]    w_y_shift;
  logic              w_x_ge;
  logic              w_y_ge;
  logic [CNT_W-1:0]  w_x_diff;
  logic [CNT_W-1:0]  w_y_diff;
  logic              w_hit;
  logic [X_W-1:0]    w_qx_lo;
  logic [Y_W-1:0]    w_qy_lo;

  // Shadow totals as seen by the divider, one entry per channel
  logic [SX_W-1:0]   w_sh_sum_x [N_CH];
  logic [SY_W-1:0]   w_sh_sum_y [N_CH];
  logic [CNT_W-1:0]  w_sh_cnt   [N_CH];
  logic [SX_W-1:0]   w_sel_sum_x;
  logic [SY_W-1:0]   w_sel_sum_y;
  logic [CNT_W-1:0]  w_sel_cnt;

  assign w_busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // Per-channel accumulators and frame-end shadows
  // --------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_acc
      logic [SX_W-1:0]  r_sum_x;
      logic [SY_W-1:0]  r_sum_y;
      logic [CNT_W-1:0] r_cnt;
      logic [SX_W-1:0]  r_sh_sum_x;
      logic [SY_W-1:0]  r_sh_sum_y;
      logic [CNT_W-1:0] r_sh_cnt;

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_sum_x    <= '0;
          r_sum_y    <= '0;
          r_cnt      <= '0;
          r_sh_sum_x <= '0;
          r_sh_sum_y <= '0;
          r_sh_cnt   <= '0;
        end else begin
          if (tabulate_in) begin
            // The strobe cycle's pixel opens the next frame.
            r_sum_x <= valid_in[gi] ? SX_W'(x_in) : '0;
            r_sum_y <= valid_in[gi] ? SY_W'(y_in) : '0;
            r_cnt   <= valid_in[gi] ? CNT_W'(1) : '0;
          end else if (valid_in[gi] && (r_cnt != '1)) begin
            // A saturated count freezes the whole channel so the ratio stays sane.
            r_sum_x <= r_sum_x + SX_W'(x_in);
            r_sum_y <= r_sum_y + SY_W'(y_in);
            r_cnt   <= r_cnt + CNT_W'(1);
          end
          // A strobe during a running sequence drops that frame's totals.
          if (tabulate_in && !w_busy) begin
            r_sh_sum_x <= r_sum_x;
            r_sh_sum_y <= r_sum_y;
            r_sh_cnt   <= r_cnt;
          end
        end
      end

      assign w_sh_sum_x[gi] = r_sh_sum_x;
      assign w_sh_sum_y[gi] = r_sh_sum_y;
      assign w_sh_cnt[gi]   = r_sh_cnt;
    end
  endgenerate

  assign w_sel_sum_x = w_sh_sum_x[r_ch];
  assign w_sel_sum_y = w_sh_sum_y[r_ch];
  assign w_sel_cnt   = w_sh_cnt[r_ch];

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (tabulate_in) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_DIV;
      S_DIV:   if (r_bit_cnt == LAST_BIT) w_state_next = S_STORE;
      S_STORE: w_state_next = (r_ch == LAST_CH) ? S_DONE : S_LOAD;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= tabulate_in && w_busy;
    end
  end

  // --------------------------------------------------------------------------
  // Restoring dividers: one quotient bit per cycle, MSB first. The dividend
  // register doubles as the quotient register as bits shift through it.
  // --------------------------------------------------------------------------
  assign w_x_shift = {r_rx, r_qx[SUM_W-1]};
  assign w_y_shift = {r_ry, r_qy[SUM_W-1]};
  assign w_x_ge    = (w_x_shift >= {1'b0, r_divisor});
  assign w_y_ge    = (w_y_shift >= {1'b0, r_divisor});
  // The difference is below the divisor whenever it is used, so CNT_W bits suffice.
  assign w_x_diff  = w_x_shift[CNT_W-1:0] - r_divisor;
  assign w_y_diff  = w_y_shift[CNT_W-1:0] - r_divisor;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ch      <= '0;
      r_bit_cnt <= '0;
      r_qx      <= '0;
      r_qy      <= '0;
      r_rx      <= '0;
      r_ry      <= '0;
      r_divisor <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ch <= '0;
        end
        S_LOAD: begin
          r_qx      <= w_sel_sum_x;
          r_qy      <= SUM_W'(w_sel_sum_y);
          r_rx      <= '0;
          r_ry      <= '0;
          r_divisor <= w_sel_cnt;
          r_bit_cnt <= '0;
        end
        S_DIV: begin
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
          // An empty channel still spends the DIV slot so frame latency stays
          // fixed, but the datapath is held so nothing is divided by zero.
          if (r_divisor != '0) begin
            r_qx <= {r_qx[SUM_W-2:0], w_x_ge};
            r_qy <= {r_qy[SUM_W-2:0], w_y_ge};
            r_rx <= w_x_ge ? w_x_diff : w_x_shift[CNT_W-1:0];
            r_ry <= w_y_ge ? w_y_diff : w_y_shift[CNT_W-1:0];
          end
        end
        S_STORE: begin
          if (r_ch != LAST_CH) begin
            r_ch <= r_ch + CH_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign w_hit   = (r_divisor >= MIN_CNT) && (r_divisor != '0);
  assign w_qx_lo = r_qx[X_W-1:0];
  assign w_qy_lo = r_qy[Y_W-1:0];

  // --------------------------------------------------------------------------
  // Result registers, written only in STORE for the channel being processed
  // --------------------------------------------------------------------------
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_out
      logic [X_W-1:0] r_x_com;
      logic [Y_W-1:0] r_y_com;
      logic           r_found;
      logic [X_W-1:0] w_x_new;
      logic [Y_W-1:0] w_y_new;

`ifdef COM_SMOOTH_EN
      // 3*prev + new fits in two extra bits; the shift drops them again.
      logic [X_W+1:0] w_x_blend;
      logic [Y_W+1:0] w_y_blend;
      assign w_x_blend = {2'b00, r_x_com} + {1'b0, r_x_com, 1'b0} + {2'b00, w_qx_lo};
      assign w_y_blend = {2'b00, r_y_com} + {1'b0, r_y_com, 1'b0} + {2'b00, w_qy_lo};
      assign w_x_new   = r_found ? w_x_blend[X_W+1:2] : w_qx_lo;
      assign w_y_new   = r_found ? w_y_blend[Y_W+1:2] : w_qy_lo;
`else
      assign w_x_new = w_qx_lo;
      assign w_y_new = w_qy_lo;
`endif

      always_ff @(posedge clk_in) begin
        if (rst_in) begin
          r_x_com <= '0;
          r_y_com <= '0;
          r_found <= 1'b0;
        end else if ((r_state == S_STORE) && (r_ch == CH_W'(gi))) begin
          if (w_hit) begin
            r_x_com <= w_x_new;
            r_y_com <= w_y_new;
            r_found <= 1'b1;
          end else begin
            r_found <= 1'b0;
          end
        end
      end

      assign x_com_out[gi*X_W +: X_W] = r_x_com;
      assign y_com_out[gi*Y_W +: Y_W] = r_y_com;
      assign found_out[gi]            = r_found;
    end
  endgenerate

  assign valid_com_out = (r_state == S_DONE);
  assign busy_out      = w_busy;
  assign overrun_out   = r_overrun;

endmodule

// File: tb/tb_multi_center_of_mass.sv
// Testbench for multi_center_of_mass: directed frames and random frames,
// each checked against a frame-level arithmetic model of the centroid rules.
module tb_multi_center_of_mass;

  localparam int N_CH       = 2;
  localparam int X_W        = 11;
  localparam int Y_W        = 10;
  localparam int CNT_W      = 17;
  localparam int MIN_PIXELS = 16;
  localparam int SUM_W      = X_W + CNT_W;
  localparam int LAT        = 1 + N_CH * (SUM_W + 2);

  logic                clk = 1'b0;
  logic                rst_in;
  logic [X_W-1:0]      x_in;
  logic [Y_W-1:0]      y_in;
  logic [N_CH-1:0]     valid_in;
  logic                tabulate_in;
  logic [N_CH*X_W-1:0] x_com_out;
  logic [N_CH*Y_W-1:0] y_com_out;
  logic [N_CH-1:0]     found_out;
  logic                valid_com_out;
  logic                busy_out;
  logic                overrun_out;

  always #5 clk = ~clk;

  multi_center_of_mass #(
    .N_CH(N_CH), .X_W(X_W), .Y_W(Y_W), .CNT_W(CNT_W), .MIN_PIXELS(MIN_PIXELS)
  ) dut (
    .clk_in(clk), .rst_in(rst_in), .x_in(x_in), .y_in(y_in),
    .valid_in(valid_in), .tabulate_in(tabulate_in),
    .x_com_out(x_com_out), .y_com_out(y_com_out), .found_out(found_out),
    .valid_com_out(valid_com_out), .busy_out(busy_out), .overrun_out(overrun_out)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: live frame totals, frozen totals, expected outputs.
  // Counts never approach 2^CNT_W here, so saturation is not modelled.
  int m_sx [N_CH];
  int m_sy [N_CH];
  int m_cnt[N_CH];
  int s_sx [N_CH];
  int s_sy [N_CH];
  int s_cnt[N_CH];
  logic [N_CH*X_W-1:0] e_x;
  logic [N_CH*Y_W-1:0] e_y;
  logic [N_CH-1:0]     e_found;

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      m_sx[c] = 0; m_sy[c] = 0; m_cnt[c] = 0;
      s_sx[c] = 0; s_sy[c] = 0; s_cnt[c] = 0;
    end
    e_x = '0; e_y = '0; e_found = '0;
  endtask

  task automatic model_pixel(input logic [N_CH-1:0] m, input int x, input int y);
    for (int c = 0; c < N_CH; c++) begin
      if (m[c]) begin
        m_sx[c] += x; m_sy[c] += y; m_cnt[c] += 1;
      end
    end
  endtask

  task automatic model_tab(input logic [N_CH-1:0] m, input int x, input int y, input bit busy);
    for (int c = 0; c < N_CH; c++) begin
      if (!busy) begin
        s_sx[c] = m_sx[c]; s_sy[c] = m_sy[c]; s_cnt[c] = m_cnt[c];
      end
      m_sx[c]  = m[c] ? x : 0;
      m_sy[c]  = m[c] ? y : 0;
      m_cnt[c] = m[c] ? 1 : 0;
    end
  endtask

  task automatic model_result();
    int qx, qy, px, py;
    for (int c = 0; c < N_CH; c++) begin
      if (s_cnt[c] >= MIN_PIXELS && s_cnt[c] > 0) begin
        qx = s_sx[c] / s_cnt[c];
        qy = s_sy[c] / s_cnt[c];
`ifdef COM_SMOOTH_EN
        if (e_found[c]) begin
          px = int'(e_x[c*X_W +: X_W]);
          py = int'(e_y[c*Y_W +: Y_W]);
          qx = (3 * px + qx) >> 2;
          qy = (3 * py + qy) >> 2;
        end
`else
        px = 0; py = 0;
`endif
        e_x[c*X_W +: X_W] = X_W'(qx);
        e_y[c*Y_W +: Y_W] = Y_W'(qy);
        e_found[c] = 1'b1;
      end else begin
        e_found[c] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pixel cycle (optionally with the frame-end strobe) and keep the
  // model in lock-step. 'busy' is the bench's own knowledge of the sequencer.
  task automatic pix(input logic [N_CH-1:0] m, input int x, input int y,
                     input bit tab, input bit busy);
    valid_in    = m;
    x_in        = X_W'(x);
    y_in        = Y_W'(y);
    tabulate_in = tab;
    if (tab) model_tab(m, x, y, busy);
    else     model_pixel(m, x, y);
    step();
    valid_in    = '0;
    tabulate_in = 1'b0;
  endtask

  task automatic feed_random(input int n);
    for (int i = 0; i < n; i++) begin
      pix(N_CH'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
          int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    end
  endtask

  // Advances until valid_com_out; 'lat' is the cycle offset from the strobe.
  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (valid_com_out !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = '0; tabulate_in = 1'b0; x_in = '0; y_in = '0;
    repeat (3) step();
    rst_in = 1'b0;
    model_clear();
    checks++; if (x_com_out !== '0) begin errors++; $display("FAIL reset_x got=%h exp=0", x_com_out); end
    checks++; if (y_com_out !== '0) begin errors++; $display("FAIL reset_y got=%h exp=0", y_com_out); end
    checks++; if (found_out !== '0) begin errors++; $display("FAIL reset_found got=%b exp=0", found_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_out); end
    checks++; if (valid_com_out !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid_com_out); end
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun_out); end
    $display("reset: outputs x=%h y=%h found=%b busy=%b", x_com_out, y_com_out, found_out, busy_out);
  endtask

  task automatic test_block();
    int lat;
    for (int yy = 50; yy <= 53; yy++)
      for (int xx = 100; xx <= 103; xx++)
        pix(2'b01, xx, yy, 1'b0, 1'b0);
    pix(2'b00, 0, 0, 1'b1, 1'b0);
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL block_busy got=%b exp=1", busy_out); end
    wait_valid(1, lat);
    model_result();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL block_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL block_x got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL block_y got=%h exp=%h", y_com_out, e_y); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL block_found got=%b exp=%b", found_out, e_found); end
    $display("block: lat=%0d x=%h y=%h found=%b", lat, x_com_out, y_com_out, found_out);
    step();
    checks++; if (valid_com_out !== 1'b0) begin errors++; $display("FAIL block_pulse got=%b exp=0", valid_com_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL block_idle got=%b exp=0", busy_out); end
  endtask

  task automatic test_below_min();
    int lat;
    for (int i = 0; i < MIN_PIXELS - 1; i++)
      pix(2'b10, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    pix(2'b00, 0, 0, 1'b1, 1'b0);
    wait_valid(1, lat);
    model_result();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL below_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL below_found got=%b exp=%b", found_out, e_found); end
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL below_x_hold got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL below_y_hold got=%h exp=%h", y_com_out, e_y); end
    $display("below_min: lat=%0d x=%h y=%h found=%b", lat, x_com_out, y_com_out, found_out);
    step();
  endtask

  task automatic test_two_ch();
    int lat;
    for (int i = 0; i < 16; i++) begin
      pix(2'b01, 10, 20, 1'b0, 1'b0);
      pix(2'b10, 300, 200, 1'b0, 1'b0);
    end
    pix(2'b00, 0, 0, 1'b1, 1'b0);
    wait_valid(1, lat);
    model_result();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL two_ch_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL two_ch_x got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL two_ch_y got=%h exp=%h", y_com_out, e_y); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL two_ch_found got=%b exp=%b", found_out, e_found); end
    $display("two_ch: lat=%0d x=%h y=%h found=%b", lat, x_com_out, y_com_out, found_out);
    step();
  endtask

  task automatic test_random();
    int lat;
    for (int f = 0; f < 6; f++) begin
      feed_random(int'($urandom_range(0, 48)));
      pix(N_CH'($urandom_range(0, 3)), int'($urandom_range(0, 2047)),
          int'($urandom_range(0, 1023)), 1'b1, 1'b0);
      wait_valid(1, lat);
      model_result();
      checks++; if (lat !== LAT) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", f, lat, LAT); end
      checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL rand%0d_x got=%h exp=%h", f, x_com_out, e_x); end
      checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL rand%0d_y got=%h exp=%h", f, y_com_out, e_y); end
      checks++; if (found_out !== e_found) begin errors++; $display("FAIL rand%0d_found got=%b exp=%b", f, found_out, e_found); end
      $display("random frame %0d: cnt=%0d/%0d x=%h y=%h found=%b", f, s_cnt[0], s_cnt[1], x_com_out, y_com_out, found_out);
      step();
    end
  endtask

  task automatic test_overrun();
    int lat;
    for (int i = 0; i < 20; i++)
      pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b1, 1'b0); // T
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_early got=%b exp=0", overrun_out); end
    // T+1..T+4: pixels that the second strobe discards
    for (int i = 0; i < 4; i++)
      pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0, 1'b1);
    pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b1, 1'b1); // T+5
    checks++; if (overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_pulse got=%b exp=1", overrun_out); end
    step();
    checks++; if (overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_width got=%b exp=0", overrun_out); end
    wait_valid(7, lat);
    model_result();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL ovr_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL ovr_x got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL ovr_y got=%h exp=%h", y_com_out, e_y); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL ovr_found got=%b exp=%b", found_out, e_found); end
    $display("overrun first: lat=%0d x=%h y=%h found=%b", lat, x_com_out, y_com_out, found_out);
    step();
    for (int i = 0; i < 16; i++)
      pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    pix(2'b00, 0, 0, 1'b1, 1'b0);
    wait_valid(1, lat);
    model_result();
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL ovr_next_x got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL ovr_next_y got=%h exp=%h", y_com_out, e_y); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL ovr_next_found got=%b exp=%b", found_out, e_found); end
    $display("overrun next frame: x=%h y=%h found=%b", x_com_out, y_com_out, found_out);
    step();
  endtask

  task automatic test_reset_mid();
    int lat;
    int pulses;
    feed_random(40);
    pix(2'b00, 0, 0, 1'b1, 1'b0);          // T
    repeat (29) step();                     // now T+30
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    model_clear();
    checks++; if (x_com_out !== '0) begin errors++; $display("FAIL rstmid_x got=%h exp=0", x_com_out); end
    checks++; if (y_com_out !== '0) begin errors++; $display("FAIL rstmid_y got=%h exp=0", y_com_out); end
    checks++; if (found_out !== '0) begin errors++; $display("FAIL rstmid_found got=%b exp=0", found_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy_out); end
    pulses = 0;
    for (int i = 0; i < 70; i++) begin
      if (valid_com_out === 1'b1) pulses++;
      step();
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", pulses); end
    for (int i = 0; i < 18; i++)
      pix(2'b11, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)), 1'b0, 1'b0);
    pix(2'b00, 0, 0, 1'b1, 1'b0);
    wait_valid(1, lat);
    model_result();
    checks++; if (lat !== LAT) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
    checks++; if (x_com_out !== e_x) begin errors++; $display("FAIL rstmid_next_x got=%h exp=%h", x_com_out, e_x); end
    checks++; if (y_com_out !== e_y) begin errors++; $display("FAIL rstmid_next_y got=%h exp=%h", y_com_out, e_y); end
    checks++; if (found_out !== e_found) begin errors++; $display("FAIL rstmid_next_found got=%b exp=%b", found_out, e_found); end
    $display("reset mid-sequence: pulses=%0d next x=%h y=%h found=%b", pulses, x_com_out, y_com_out, found_out);
    step();
  endtask

  initial begin
    test_reset();
    test_block();
    test_below_min();
    test_two_ch();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
